// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback selector encodings and helpers
package wb_pkg;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_PC   = 2'b01,
    SEL_IREG = 2'b10,
    SEL_FREG = 2'b11
  } wb_sel_e;

  function automatic logic sel_is_reg(input wb_sel_e sel);
    return (sel == SEL_IREG) || (sel == SEL_FREG);
  endfunction

endpackage

// File: rtl/write_arbiter_if.sv
// rtl/write_arbiter_if.sv - writeback source channels and write-port bundle
interface write_arbiter_if #(
  parameter int NCH   = 2,
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);

  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [2*NCH-1:0]     in_sel;
  logic [XLEN*NCH-1:0]  in_data;
  logic [RADDR*NCH-1:0] in_rd;
  logic                 wr_ready;
  logic [NCH-1:0]       done;
  logic                 pcenable;
  logic [XLEN-1:0]      next_pc;
  logic                 wenable;
  logic                 fmode;
  logic [RADDR-1:0]     wreg;
  logic [XLEN-1:0]      wdata;

  modport master (
    output in_valid, in_sel, in_data, in_rd, wr_ready,
    input  in_ready, done, pcenable, next_pc, wenable, fmode, wreg, wdata
  );

  modport slave (
    input  in_valid, in_sel, in_data, in_rd, wr_ready,
    output in_ready, done, pcenable, next_pc, wenable, fmode, wreg, wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant, pointer moves past the winner on advance
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  input  logic         advance
);

  localparam int            PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0]   NW = (PW+1)'(N);
  localparam logic [PW:0]   ONE = (PW+1)'(1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   idx, nxt;
  logic          found;

  // Scan from the pointer with wrap; the first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    idx   = '0;
    nxt   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= NW) idx = idx - NW;
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        grant[idx[PW-1:0]] = 1'b1;
        nxt = idx + ONE;
        if (nxt >= NW) nxt = '0;
        if (advance) ptr_d = nxt[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/write_arbiter.sv
// rtl/write_arbiter.sv - per-channel holding slots feeding one PC port and one register write port
module write_arbiter
  import wb_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic          clk,
  input  logic          rstn,
  write_arbiter_if.slave bus
);

  logic [NCH-1:0]   full_q, full_d;
  wb_sel_e          sel_q  [NCH];
  wb_sel_e          sel_d  [NCH];
  logic [RADDR-1:0] rd_q   [NCH];
  logic [RADDR-1:0] rd_d   [NCH];
  logic [XLEN-1:0]  data_q [NCH];
  logic [XLEN-1:0]  data_d [NCH];

  logic [NCH-1:0]   done_q, done_d;
  logic             pcen_q, pcen_d;
  logic [XLEN-1:0]  next_pc_q, next_pc_d;
  logic             wen_q, wen_d;
  logic             fmode_q, fmode_d;
  logic [RADDR-1:0] wreg_q, wreg_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;

  logic [NCH-1:0]   none_slot, pc_req, reg_req, pc_grant, reg_grant;
  logic [NCH-1:0]   retire, ready, accept;
  logic             pc_found;

  // Writes to x0 are architecturally void, so they retire like sel=none.
  always_comb begin
    none_slot = '0;
    pc_req    = '0;
    reg_req   = '0;
    for (int i = 0; i < NCH; i++) begin
      none_slot[i] = full_q[i] && ((sel_q[i] == SEL_NONE) ||
                                   ((sel_q[i] == SEL_IREG) && (rd_q[i] == '0)));
      pc_req[i]    = full_q[i] && (sel_q[i] == SEL_PC);
      reg_req[i]   = full_q[i] && bus.wr_ready && sel_is_reg(sel_q[i]) && !none_slot[i];
    end
  end

  always_comb begin
    pc_grant = '0;
    pc_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pc_req[i] && !pc_found) begin
        pc_grant[i] = 1'b1;
        pc_found    = 1'b1;
      end
    end
  end

  rr_arbiter #(.N(NCH)) u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .req     (reg_req),
    .grant   (reg_grant),
    .advance (bus.wr_ready)
  );

  assign retire = none_slot | pc_grant | reg_grant;
  assign ready  = ~full_q | retire;
  assign accept = bus.in_valid & ready;

  always_comb begin
    full_d    = full_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    data_d    = data_q;
    next_pc_d = next_pc_q;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    fmode_d   = fmode_q;
    done_d    = retire;
    pcen_d    = |pc_grant;
    wen_d     = |reg_grant;
    for (int i = 0; i < NCH; i++) begin
      if (pc_grant[i]) next_pc_d = data_q[i];
      if (reg_grant[i]) begin
        wreg_d  = rd_q[i];
        wdata_d = data_q[i];
        fmode_d = sel_q[i][0];
      end
      // A retiring slot may refill on the same edge.
      if (accept[i]) begin
        full_d[i] = 1'b1;
        sel_d[i]  = wb_sel_e'(bus.in_sel[2*i +: 2]);
        rd_d[i]   = bus.in_rd[RADDR*i +: RADDR];
        data_d[i] = bus.in_data[XLEN*i +: XLEN];
      end else if (retire[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_q    <= '0;
      done_q    <= '0;
      pcen_q    <= 1'b0;
      next_pc_q <= '0;
      wen_q     <= 1'b0;
      fmode_q   <= 1'b0;
      wreg_q    <= '0;
      wdata_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        sel_q[i]  <= SEL_NONE;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      full_q    <= full_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      done_q    <= done_d;
      pcen_q    <= pcen_d;
      next_pc_q <= next_pc_d;
      wen_q     <= wen_d;
      fmode_q   <= fmode_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.done     = done_q;
  assign bus.pcenable = pcen_q;
  assign bus.next_pc  = next_pc_q;
  assign bus.wenable  = wen_q;
  assign bus.fmode    = fmode_q;
  assign bus.wreg     = wreg_q;
  assign bus.wdata    = wdata_q;

endmodule

// File: tb/tb_write_arbiter.sv
// tb/tb_write_arbiter.sv - directed scenarios then random traffic against a reference model
module tb_write_arbiter;

  localparam int NCH   = 2;
  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  write_arbiter_if #(.NCH(NCH), .XLEN(XLEN), .RADDR(RADDR)) bus ();

  write_arbiter #(.NCH(NCH), .XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic             m_full [NCH];
  logic [1:0]       m_sel  [NCH];
  logic [RADDR-1:0] m_rd   [NCH];
  logic [XLEN-1:0]  m_data [NCH];
  int               m_ptr;
  logic [NCH-1:0]   e_done, e_ready;
  logic             e_pcen, e_wen, e_fmode;
  logic [XLEN-1:0]  e_next_pc, e_wdata;
  logic [RADDR-1:0] e_wreg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic v, input logic [1:0] s,
                        input logic [RADDR-1:0] rd, input logic [XLEN-1:0] d);
    bus.in_valid[i]            = v;
    bus.in_sel[2*i +: 2]       = s;
    bus.in_rd[RADDR*i +: RADDR] = rd;
    bus.in_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic expect_ctl(input string tag, input logic [NCH-1:0] done,
                            input logic pcen, input logic wen);
    check({tag, "_done"}, 64'(bus.done), 64'(done));
    check({tag, "_pcen"}, 64'(bus.pcenable), 64'(pcen));
    check({tag, "_wen"},  64'(bus.wenable), 64'(wen));
  endtask

  function automatic logic m_is_reg(input int i);
    return (m_sel[i] == 2'b11) || (m_sel[i] == 2'b10 && m_rd[i] != '0);
  endfunction

  // Decide this cycle's retirements from the spec rules and advance the model.
  task automatic model_cycle();
    int pc_win, reg_win, j;
    pc_win  = -1;
    reg_win = -1;
    e_done  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m_full[i] && (m_sel[i] == 2'b00 || (m_sel[i] == 2'b10 && m_rd[i] == '0)))
        e_done[i] = 1'b1;
      if (pc_win < 0 && m_full[i] && m_sel[i] == 2'b01) pc_win = i;
    end
    if (bus.wr_ready) begin
      for (int k = 0; k < NCH; k++) begin
        j = (m_ptr + k) % NCH;
        if (reg_win < 0 && m_full[j] && m_is_reg(j)) reg_win = j;
      end
    end
    if (pc_win >= 0) e_done[pc_win] = 1'b1;
    if (reg_win >= 0) e_done[reg_win] = 1'b1;
    for (int i = 0; i < NCH; i++) e_ready[i] = !m_full[i] || e_done[i];
    e_pcen = (pc_win >= 0);
    e_wen  = (reg_win >= 0);
    if (pc_win >= 0) e_next_pc = m_data[pc_win];
    if (reg_win >= 0) begin
      e_wreg  = m_rd[reg_win];
      e_wdata = m_data[reg_win];
      e_fmode = m_sel[reg_win][0];
      m_ptr   = (reg_win + 1) % NCH;
    end
    for (int i = 0; i < NCH; i++) begin
      if (bus.in_valid[i] && e_ready[i]) begin
        m_full[i] = 1'b1;
        m_sel[i]  = bus.in_sel[2*i +: 2];
        m_rd[i]   = bus.in_rd[RADDR*i +: RADDR];
        m_data[i] = bus.in_data[XLEN*i +: XLEN];
      end else if (e_done[i]) begin
        m_full[i] = 1'b0;
      end
    end
  endtask

  initial begin
    bus.in_valid = '0;
    bus.in_sel   = '0;
    bus.in_data  = '0;
    bus.in_rd    = '0;
    bus.wr_ready = 1'b1;
    repeat (2) tick();

    // reset state
    expect_ctl("rst", 2'b00, 1'b0, 1'b0);
    check("rst_wreg",    64'(bus.wreg), 64'(0));
    check("rst_wdata",   64'(bus.wdata), 64'(0));
    check("rst_next_pc", 64'(bus.next_pc), 64'(0));
    check("rst_fmode",   64'(bus.fmode), 64'(0));
    check("rst_ready",   64'(bus.in_ready), 64'(2'b11));
    rstn = 1'b1;

    // contention: both channels every cycle, round-robin from pointer 0
    set_ch(0, 1'b1, 2'b10, 5'd1, 32'h0000_00A0);
    set_ch(1, 1'b1, 2'b11, 5'd2, 32'h0000_00B1);
    tick();
    expect_ctl("rr_cap", 2'b00, 1'b0, 1'b0);
    check("rr_cap_ready", 64'(bus.in_ready), 64'(2'b01));
    tick();
    expect_ctl("rr_g0", 2'b01, 1'b0, 1'b1);
    check("rr_g0_wreg",  64'(bus.wreg), 64'(1));
    check("rr_g0_fmode", 64'(bus.fmode), 64'(0));
    check("rr_g0_ready", 64'(bus.in_ready), 64'(2'b10));
    tick();
    expect_ctl("rr_g1", 2'b10, 1'b0, 1'b1);
    check("rr_g1_wreg",  64'(bus.wreg), 64'(2));
    check("rr_g1_fmode", 64'(bus.fmode), 64'(1));
    check("rr_g1_wdata", 64'(bus.wdata), 64'(32'hB1));
    tick();
    expect_ctl("rr_g2", 2'b01, 1'b0, 1'b1);
    check("rr_g2_wreg",  64'(bus.wreg), 64'(1));
    set_ch(0, 1'b0, 2'b00, 5'd0, 32'h0);
    set_ch(1, 1'b0, 2'b00, 5'd0, 32'h0);
    repeat (3) tick();
    expect_ctl("rr_idle", 2'b00, 1'b0, 1'b0);

    // single integer write
    set_ch(0, 1'b1, 2'b10, 5'd3, 32'h1234_5678);
    tick();
    set_ch(0, 1'b0, 2'b00, 5'd0, 32'h0);
    expect_ctl("int_cap", 2'b00, 1'b0, 1'b0);
    tick();
    expect_ctl("int_wr", 2'b01, 1'b0, 1'b1);
    check("int_wreg",  64'(bus.wreg), 64'(3));
    check("int_wdata", 64'(bus.wdata), 64'(32'h1234_5678));
    check("int_fmode", 64'(bus.fmode), 64'(0));
    tick();
    expect_ctl("int_after", 2'b00, 1'b0, 1'b0);
    check("int_hold_wreg", 64'(bus.wreg), 64'(3));

    // PC and register retire together
    set_ch(0, 1'b1, 2'b01, 5'd0, 32'h0000_0100);
    set_ch(1, 1'b1, 2'b10, 5'd5, 32'h0000_ABCD);
    tick();
    set_ch(0, 1'b0, 2'b00, 5'd0, 32'h0);
    set_ch(1, 1'b0, 2'b00, 5'd0, 32'h0);
    tick();
    expect_ctl("par", 2'b11, 1'b1, 1'b1);
    check("par_next_pc", 64'(bus.next_pc), 64'(32'h100));
    check("par_wreg",    64'(bus.wreg), 64'(5));
    check("par_wdata",   64'(bus.wdata), 64'(32'hABCD));
    tick();
    expect_ctl("par_after", 2'b00, 1'b0, 1'b0);
    check("par_hold_pc", 64'(bus.next_pc), 64'(32'h100));

    // backpressure
    bus.wr_ready = 1'b0;
    set_ch(0, 1'b1, 2'b10, 5'd7, 32'h0000_CAFE);
    tick();
    set_ch(0, 1'b0, 2'b00, 5'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      check("bp_ready0", 64'(bus.in_ready[0]), 64'(0));
      expect_ctl("bp_hold", 2'b00, 1'b0, 1'b0);
      tick();
    end
    bus.wr_ready = 1'b1;
    tick();
    expect_ctl("bp_rel", 2'b01, 1'b0, 1'b1);
    check("bp_wreg",  64'(bus.wreg), 64'(7));
    check("bp_wdata", 64'(bus.wdata), 64'(32'hCAFE));

    // x0 write and sel=none
    set_ch(0, 1'b1, 2'b10, 5'd0, 32'h0000_0055);
    set_ch(1, 1'b1, 2'b00, 5'd9, 32'h0000_0066);
    tick();
    set_ch(0, 1'b0, 2'b00, 5'd0, 32'h0);
    set_ch(1, 1'b0, 2'b00, 5'd0, 32'h0);
    tick();
    expect_ctl("x0", 2'b11, 1'b0, 1'b0);
    check("x0_hold_wreg", 64'(bus.wreg), 64'(7));

    // reset with both slots full under backpressure
    bus.wr_ready = 1'b0;
    set_ch(0, 1'b1, 2'b10, 5'd4, 32'h0000_0044);
    set_ch(1, 1'b1, 2'b11, 5'd6, 32'h0000_0066);
    tick();
    set_ch(0, 1'b0, 2'b00, 5'd0, 32'h0);
    set_ch(1, 1'b0, 2'b00, 5'd0, 32'h0);
    check("mr_full_ready", 64'(bus.in_ready), 64'(2'b00));
    rstn = 1'b0;
    #1;
    expect_ctl("mr_rst", 2'b00, 1'b0, 1'b0);
    check("mr_wreg",    64'(bus.wreg), 64'(0));
    check("mr_wdata",   64'(bus.wdata), 64'(0));
    check("mr_next_pc", 64'(bus.next_pc), 64'(0));
    check("mr_fmode",   64'(bus.fmode), 64'(0));
    bus.wr_ready = 1'b1;
    tick();
    check("mr_ready", 64'(bus.in_ready), 64'(2'b11));
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_ctl("mr_post", 2'b00, 1'b0, 1'b0);
    end

    // random traffic against the model, starting from the post-reset state
    for (int i = 0; i < NCH; i++) begin
      m_full[i] = 1'b0;
      m_sel[i]  = '0;
      m_rd[i]   = '0;
      m_data[i] = '0;
    end
    m_ptr = 0;
    e_next_pc = '0;
    e_wreg    = '0;
    e_wdata   = '0;
    e_fmode   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NCH; i++)
        set_ch(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               RADDR'($urandom_range(0, 3)), $urandom);
      bus.wr_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_cycle();
      check("rnd_ready", 64'(bus.in_ready), 64'(e_ready));
      tick();
      expect_ctl("rnd", e_done, e_pcen, e_wen);
      check("rnd_next_pc", 64'(bus.next_pc), 64'(e_next_pc));
      check("rnd_wreg",    64'(bus.wreg), 64'(e_wreg));
      check("rnd_wdata",   64'(bus.wdata), 64'(e_wdata));
      check("rnd_fmode",   64'(bus.fmode), 64'(e_fmode));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
